load_store_unit: RTL and testbench

//  Data-side memory stage downstream of the core datapath. Takes ALUResult (address) and

---
 rtl/load_store_unit_if.sv | 33 +++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data-memory valid/ready bus between the load/store unit and memory
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_ready,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_ready,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-side memory stage: one bus transaction per load/store with stall, format and timeout
module load_store_unit #(
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [2:0]          req_funct3,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    output logic                stall,
    output logic [31:0]         load_data,
    output logic                load_valid,
    output logic                misaligned,
    output logic                bus_error,
    load_store_unit_if.master   mem
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state;
    logic [CW-1:0]  count;
    logic [1:0]     lat_lane;
    logic [2:0]     lat_funct3;
    logic           lat_write;

    logic           req_illegal;
    logic           req_misaligned;
    logic [3:0]     next_be;
    logic [31:0]    next_wdata;
    logic [31:0]    lane_word;
    logic [31:0]    formatted;
    logic           timeout_hit;

    // Reset forces the core free immediately, even while it still holds req_valid.
    assign stall = !reset && ((state == IDLE && req_valid) || state == REQ || state == RESP);

    // The counter can pass TIMEOUT-1 only when a load is accepted on the last REQ cycle; >= still ends it.
    assign timeout_hit = (count >= LAST_COUNT);

    // Legality, byte enables and lane-replicated store data for the incoming request.
    always_comb begin
        req_illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                         (req_write && req_funct3[2]);
        req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        next_be    = 4'b1111;
        next_wdata = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                next_be    = 4'b0001 << req_addr[1:0];
                next_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                next_be    = 4'b0011 << {req_addr[1], 1'b0};
                next_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                next_be    = 4'b1111;
                next_wdata = req_wdata;
            end
        endcase
    end

    // Select the addressed lane of the read word and sign/zero-extend it.
    always_comb begin
        lane_word = mem.mem_rdata >> {lat_lane, 3'b000};
        case (lat_funct3)
            3'b000:  formatted = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b001:  formatted = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b100:  formatted = {24'd0, lane_word[7:0]};
            3'b101:  formatted = {16'd0, lane_word[15:0]};
            default: formatted = mem.mem_rdata;
        endcase
    end

    // Transaction FSM with registered bus fields and one-cycle result pulses shown in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            lat_lane      <= 2'b00;
            lat_funct3    <= 3'b000;
            lat_write     <= 1'b0;
            load_data     <= 32'd0;
            load_valid    <= 1'b0;
            misaligned    <= 1'b0;
            bus_error     <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'd0;
            mem.mem_be    <= 4'd0;
            mem.mem_wdata <= 32'd0;
        end else begin
            load_valid <= 1'b0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
                    if (req_valid) begin
                        if (req_illegal || req_misaligned) begin
                            misaligned <= 1'b1;
                            state      <= DONE;
                        end else begin
                            lat_lane      <= req_addr[1:0];
                            lat_funct3    <= req_funct3;
                            lat_write     <= req_write;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= req_write;
                            mem.mem_addr  <= {req_addr[31:2], 2'b00};
                            mem.mem_be    <= next_be;
                            mem.mem_wdata <= next_wdata;
                            state         <= REQ;
                        end
                    end
                end
                REQ: begin
                    count <= count + 1'b1;
                    if (mem.mem_ready || timeout_hit) begin
                        mem.mem_req   <= 1'b0;
                        mem.mem_we    <= 1'b0;
                        mem.mem_addr  <= 32'd0;
                        mem.mem_be    <= 4'd0;
                        mem.mem_wdata <= 32'd0;
                    end
                    if (mem.mem_ready) begin
                        state <= lat_write ? DONE : RESP;
                    end else if (timeout_hit) begin
                        bus_error <= 1'b1;
                        load_data <= 32'd0;
                        state     <= DONE;
                    end
                end
                RESP: begin
                    count <= count + 1'b1;
                    if (mem.mem_rvalid) begin
                        load_data  <= formatted;
                        load_valid <= 1'b1;
                        state      <= DONE;
                    end else if (timeout_hit) begin
                        bus_error <= 1'b1;
                        load_data <= 32'd0;
                        state     <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit against a behavioural model
module tb_load_store_unit;
    localparam int TO = 16;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misaligned;
    logic        bus_error;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .misaligned (misaligned),
        .bus_error  (bus_error),
        .mem        (bus.master)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    logic [31:0] last_load = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'd2) return 4;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int n;
        logic [31:0] v;
        n = size_of(f3);
        v = rdata >> (8 * (addr % 4));
        if (n == 1) begin
            v = v % 256;
            if (f3 == 3'd0 && v >= 128) v = v | 32'hFFFF_FF00;
        end else if (n == 2) begin
            v = v % 65536;
            if (f3 == 3'd1 && v >= 32768) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // rdy_dly / rv_dly: cycles of wait before mem_ready / mem_rvalid, negative = never
    task automatic run_txn(input string name, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int rdy_dly, input int rv_dly);
        int          n;
        logic        legal;
        logic        bad;
        logic        exp_timeout;
        int          exp_stalls;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        int          stalls;
        int          req_cnt;
        int          resp_cnt;
        logic        in_resp;
        logic        go_resp;
        logic        saw_req;
        logic        quiet_bad;
        logic        done;
        logic [31:0] got_addr, got_wdata;
        logic [3:0]  got_be;
        logic        got_we;

        n     = size_of(f3);
        legal = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        bad   = !legal || (addr % n != 0);
        exp_be    = 4'((32'd1 << n) - 1) << (addr % 4);
        exp_wdata = (n == 1) ? (wdata % 256) * 32'h0101_0101 :
                    (n == 2) ? (wdata % 65536) * 32'h0001_0001 : wdata;
        if (bad) begin
            exp_timeout = 1'b0;
            exp_stalls  = 1;
        end else if (rdy_dly < 0 || rdy_dly >= TO) begin
            exp_timeout = 1'b1;
            exp_stalls  = 1 + TO;
        end else if (wr) begin
            exp_timeout = 1'b0;
            exp_stalls  = 2 + rdy_dly;
        end else if (rv_dly < 0 || rdy_dly + 1 + rv_dly >= TO) begin
            exp_timeout = 1'b1;
            exp_stalls  = 1 + TO;
        end else begin
            exp_timeout = 1'b0;
            exp_stalls  = 3 + rdy_dly + rv_dly;
        end

        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        stalls = 0; req_cnt = 0; resp_cnt = 0;
        in_resp = 1'b0; saw_req = 1'b0; quiet_bad = 1'b0; done = 1'b0;
        got_addr = 0; got_wdata = 0; got_be = 0; got_we = 0;
        for (int c = 0; c < 4 * TO + 20 && !done; c++) begin
            if (c > 0) @(negedge clk);
            go_resp        = 1'b0;
            bus.mem_ready  = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
            if (bus.mem_req) begin
                if (!saw_req) begin
                    got_addr  = bus.mem_addr;
                    got_be    = bus.mem_be;
                    got_wdata = bus.mem_wdata;
                    got_we    = bus.mem_we;
                end
                saw_req = 1'b1;
                bus.mem_rvalid = 1'($urandom % 2);
                if (rdy_dly >= 0 && req_cnt == rdy_dly) begin
                    bus.mem_ready = 1'b1;
                    go_resp = !wr;
                end
                req_cnt++;
            end else begin
                if (bus.mem_we || bus.mem_be != 4'd0 || bus.mem_wdata != 32'd0) quiet_bad = 1'b1;
                if (in_resp) begin
                    if (rv_dly >= 0 && resp_cnt == rv_dly) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = rdata;
                    end
                    resp_cnt++;
                end
            end
            #1;
            if (stall) stalls++;
            else done = 1'b1;
            if (go_resp) in_resp = 1'b1;
        end

        if (!done) check({name, "_bound"}, 32'd0, 32'd1);
        if (!bad && !exp_timeout && !wr) last_load = model_load(f3, addr, rdata);
        if (exp_timeout) last_load = 32'd0;
        check({name, "_stalls"},     32'(stalls), 32'(exp_stalls));
        check({name, "_misaligned"}, {31'd0, misaligned}, {31'd0, bad});
        check({name, "_bus_error"},  {31'd0, bus_error}, {31'd0, exp_timeout});
        check({name, "_load_valid"}, {31'd0, load_valid}, {31'd0, !bad && !exp_timeout && !wr});
        check({name, "_load_data"},  load_data, last_load);
        check({name, "_saw_req"},    {31'd0, saw_req}, {31'd0, !bad});
        check({name, "_bus_quiet"},  {31'd0, quiet_bad}, 32'd0);
        if (!bad) begin
            check({name, "_mem_addr"}, got_addr, addr & 32'hFFFF_FFFC);
            check({name, "_mem_we"},   {31'd0, got_we}, {31'd0, wr});
            check({name, "_mem_be"},   {28'd0, got_be}, {28'd0, exp_be});
            check({name, "_mem_wdata"}, got_wdata, exp_wdata);
        end

        @(negedge clk);
        req_valid      = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        #1;
        check({name, "_idle"}, {28'd0, stall, load_valid, misaligned, bus_error}, 32'd0);
    endtask

    initial begin
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          rd, rv;
        int          pick;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        req_valid = 1'b1;
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_outputs", {29'd0, load_valid, misaligned, bus_error}, 32'd0);
        check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        run_txn("sw",  1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'd0, 0, 0);
        run_txn("sb",  1'b1, 3'd0, 32'h103, 32'h0000_00AB, 32'd0, 0, 0);
        run_txn("lb",  1'b0, 3'd0, 32'h102, 32'd0, 32'h12F4_5678, 0, 0);
        run_txn("lbu", 1'b0, 3'd4, 32'h102, 32'd0, 32'h12F4_5678, 0, 0);
        run_txn("lhu", 1'b0, 3'd5, 32'h102, 32'd0, 32'h12F4_5678, 1, 2);
        run_txn("lh_mis", 1'b0, 3'd1, 32'h101, 32'd0, 32'd0, 0, 0);
        run_txn("sw_ilg", 1'b1, 3'd4, 32'h100, 32'h1, 32'd0, 0, 0);
        run_txn("lw_ilg", 1'b0, 3'd3, 32'h100, 32'h1, 32'd0, 0, 0);
        run_txn("lw_to", 1'b0, 3'd2, 32'h200, 32'd0, 32'h5555_5555, 0, -1);
        run_txn("sw_to", 1'b1, 3'd2, 32'h204, 32'h77, 32'd0, -1, 0);
        run_txn("sw_edge", 1'b1, 3'd1, 32'h206, 32'hBEEF, 32'd0, TO - 1, 0);
        run_txn("lw_edge", 1'b0, 3'd2, 32'h208, 32'd0, 32'hCAFE_F00D, 2, TO - 3);

        for (int i = 0; i < 80; i++) begin
            wr   = 1'($urandom % 2);
            f3   = 3'($urandom % 8);
            addr = $urandom;
            if ($urandom % 4 != 0) addr[1:0] = (size_of(f3) == 1) ? addr[1:0] :
                                               (size_of(f3) == 2) ? {addr[1], 1'b0} : 2'b00;
            pick = int'($urandom % 16);
            rd   = (pick == 0) ? -1 : int'($urandom % 4);
            rv   = (pick == 1) ? -1 : int'($urandom % 4);
            run_txn("rnd", wr, f3, addr, $urandom, $urandom, rd, rv);
        end

        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h300;
        @(negedge clk);
        check("rst_mid_req", {31'd0, bus.mem_req}, 32'd1);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check("rst_mid_stall_before", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_stall", {31'd0, stall}, 32'd0);
        check("rst_mid_mem_req", {31'd0, bus.mem_req}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        req_valid = 1'b0;
        last_load = 32'd0;
        for (int k = 0; k < 3; k++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'h1234_5678;
            #1;
            check("rst_late_rvalid", {31'd0, load_valid}, 32'd0);
            @(negedge clk);
        end
        bus.mem_rvalid = 1'b0;
        check("rst_load_data_clr", load_data, last_load);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
